// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system ID checker: Avalon-MM read master.
//
// It reads word 0 (system ID) and then word 1 (build timestamp) from the sysid
// slave and compares them against values fixed at generation time. The
// resulting pass/fail/timeout flags gate CPU reset release and drive a debug LED.
//
// Optional feature: define SYSID_CHECKER_RETRY_EN to retry failed checks up to
// MAX_RETRIES times. That build also adds the retry_count output.
//
// Ports:
//   clock, reset      single clock; synchronous active-high reset
//   start             pulse; begins a check when idle
//   avm_address       word address (0 = ID, 1 = timestamp)
//   avm_read          read request
//   avm_waitrequest   slave stall
//   avm_readdata      read data
//   busy              check in progress
//   done              one-cycle pulse when a check completes
//   id_ok, ts_ok      last captured ID / timestamp matched expectation
//   timeout           last check aborted because a read phase ran too long
//   id_value          last captured ID word
//   ts_value          last captured timestamp word
//   retry_count       retries used by the current/last check (retry build only)
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1453203800,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  output logic [1:0]  retry_count
`endif
);

  localparam int unsigned PHASE_W  = 8;
  localparam int unsigned PHASE_CW = PHASE_W + 1;
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned RETRY_W  = 2;
  localparam int unsigned RETRY_CW = RETRY_W + 1;

`ifdef SYSID_CHECKER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam bit                  LAT_ZERO    = (READ_LATENCY == 0);
  localparam logic [LAT_W-1:0]    LAT_TARGET  = LAT_W'(READ_LATENCY);
  localparam logic [PHASE_CW-1:0] PHASE_LIMIT = PHASE_CW'(TIMEOUT_CYCLES);
  localparam logic [RETRY_CW-1:0] RETRY_LIMIT = RETRY_CW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_LAT,
    TS_REQ,
    TS_LAT,
    FINISH
  } state_t;

  state_t               state;
  logic [PHASE_W-1:0]   phase_cnt;
  logic [LAT_W-1:0]     lat_cnt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 auto_pending;

  logic in_req_c;
  logic in_lat_c;
  logic begin_c;
  logic accept_c;
  logic capture_c;
  logic to_lat_c;
  logic expire_c;
  logic finish_c;
  logic pass_c;
  logic fail_c;
  logic restart_c;
  logic end_c;

  // Event decode for the sequencer; priorities are resolved here so the
  // register block only acts on mutually exclusive events.
  always_comb begin
    in_req_c  = 1'b0;
    in_lat_c  = 1'b0;
    begin_c   = 1'b0;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    to_lat_c  = 1'b0;
    expire_c  = 1'b0;
    finish_c  = 1'b0;
    pass_c    = 1'b0;
    fail_c    = 1'b0;
    restart_c = 1'b0;
    end_c     = 1'b0;

    in_req_c  = (state == ID_REQ) || (state == TS_REQ);
    in_lat_c  = (state == ID_LAT) || (state == TS_LAT);
    // A start arriving with done is dropped so one request yields one check.
    begin_c   = (state == IDLE) && (auto_pending || (start && !done));
    accept_c  = in_req_c && avm_read && !avm_waitrequest;
    capture_c = (accept_c && LAT_ZERO) || (in_lat_c && (lat_cnt == LAT_TARGET));
    to_lat_c  = accept_c && !LAT_ZERO;
    // Timeout fires on the cycle the phase counter would reach the limit.
    expire_c  = (in_req_c || in_lat_c) && !accept_c && !capture_c &&
                (({1'b0, phase_cnt} + PHASE_CW'(1)) >= PHASE_LIMIT);
    finish_c  = (state == FINISH);
    pass_c    = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
    fail_c    = expire_c || (finish_c && !pass_c);
    restart_c = fail_c && RETRY_EN && ({1'b0, retry_cnt} < RETRY_LIMIT);
    end_c     = (finish_c || expire_c) && !restart_c;
  end

  // Sequencer state, bus outputs, captured words and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      lat_cnt      <= '0;
      retry_cnt    <= '0;
      auto_pending <= AUTO_START;
      avm_address  <= 1'b0;
      avm_read     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
    end else begin
      done <= 1'b0;

      if (begin_c) begin
        auto_pending <= 1'b0;
        retry_cnt    <= '0;
      end
      if (restart_c) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end

      if (begin_c || restart_c) begin
        // Fresh ID read; status from the previous attempt is withdrawn.
        state       <= ID_REQ;
        busy        <= 1'b1;
        avm_read    <= 1'b1;
        avm_address <= 1'b0;
        phase_cnt   <= '0;
        lat_cnt     <= '0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout     <= 1'b0;
      end else if (capture_c) begin
        // avm_address still names the word being returned in both REQ and LAT.
        if (avm_address) begin
          ts_value <= avm_readdata;
          state    <= FINISH;
          avm_read <= 1'b0;
        end else begin
          id_value    <= avm_readdata;
          state       <= TS_REQ;
          avm_read    <= 1'b1;
          avm_address <= 1'b1;
          phase_cnt   <= '0;
          lat_cnt     <= '0;
        end
      end else if (to_lat_c) begin
        avm_read  <= 1'b0;
        lat_cnt   <= LAT_W'(1);
        phase_cnt <= phase_cnt + PHASE_W'(1);
        state     <= avm_address ? TS_LAT : ID_LAT;
      end else if (end_c) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b1;
        avm_read <= 1'b0;
        if (expire_c) begin
          timeout <= 1'b1;
          id_ok   <= 1'b0;
          ts_ok   <= 1'b0;
        end else begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
        end
      end else if (in_req_c || in_lat_c) begin
        phase_cnt <= phase_cnt + PHASE_W'(1);
        if (in_lat_c) begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end
    end
  end

`ifdef SYSID_CHECKER_RETRY_EN
  assign retry_count = retry_cnt;
`endif

endmodule
